// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the ALU control decoder, plus the
// state encoding used by the sequential executor.
//   A_AND..A_SLTU : 4-bit ALU control codes (12..15 are unassigned)
//   state_t       : executor FSM states
//   is_shift()    : true for the arithmetic-right-shift codes
package alu_pkg;

    localparam logic [3:0] A_AND   = 4'd0;
    localparam logic [3:0] A_OR    = 4'd1;
    localparam logic [3:0] A_NAND  = 4'd2;
    localparam logic [3:0] A_NOR   = 4'd3;
    localparam logic [3:0] A_ADDU  = 4'd4;
    localparam logic [3:0] A_SUBU  = 4'd5;
    localparam logic [3:0] A_SLT   = 4'd6;
    localparam logic [3:0] A_EQUAL = 4'd7;
    localparam logic [3:0] A_SRA   = 4'd8;
    localparam logic [3:0] A_SRAV  = 4'd9;
    localparam logic [3:0] A_LUI   = 4'd10;
    localparam logic [3:0] A_SLTU  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == A_SRA) || (ctrl == A_SRAV);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: purely combinational single-cycle ALU operations.
// Shift codes and unassigned codes (12-15) return 0; shifts are handled in
// the executor top level.
// Ports:
//   ctrl_i   ALU control code
//   src1_i   operand 1
//   src2_i   operand 2
//   result_o combinational result
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            A_AND:   result_o = src1_i & src2_i;
            A_OR:    result_o = src1_i | src2_i;
            A_NAND:  result_o = ~(src1_i & src2_i);
            A_NOR:   result_o = ~(src1_i | src2_i);
            A_ADDU:  result_o = src1_i + src2_i;
            A_SUBU:  result_o = src1_i - src2_i;
            A_SLT:   result_o = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            A_EQUAL: result_o = {{(DATA_W-1){1'b0}}, (src1_i == src2_i)};
            A_LUI:   result_o = src2_i << 16;
            A_SLTU:  result_o = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execution-stage ALU consumer with valid/ready on both sides.
// Single-cycle ops complete in one cycle; SRA/SRAV shift iteratively
// SHIFT_STEP bits per cycle, or in one cycle with ALU_FAST_SHIFT_EN defined.
// Ports:
//   clk_i, rst_i (async, active low)
//   valid_i/ready_o       request handshake: ctrl_i, src1_i, src2_i, shamt_i
//   valid_o/ready_i       result handshake: result_o, zero_o
// Configuration macro: ALU_FAST_SHIFT_EN (barrel shifter, SHIFT_STEP ignored)
//
// state   | meaning
// S_IDLE  | waiting for a request
// S_SHIFT | iterative arithmetic shift in progress, request side stalled
// S_DONE  | result held on result_o until consumer takes it
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [4:0]        rem_q, rem_d;

    logic [DATA_W-1:0] core_res;
    logic [DATA_W-1:0] fast_res;
    logic [DATA_W-1:0] step_res;
    logic [4:0]        amt_in;
    logic [4:0]        step;
    logic              accept;

    alu_comb_core #(.DATA_W(DATA_W)) u_core (
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .result_o (core_res)
    );

    assign amt_in   = (ctrl_i == A_SRA) ? shamt_i : src1_i[4:0];
    assign fast_res = $signed(src2_i) >>> amt_in;
    // Last step may be shorter than SHIFT_STEP when k is not a multiple of it.
    assign step     = (rem_q < STEP) ? rem_q : STEP;
    assign step_res = $signed(shreg_q) >>> step;

    assign valid_o  = (state_q == S_DONE);
    assign ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
    assign accept   = valid_i && ready_o;
    assign result_o = result_q;
    assign zero_o   = (result_q == '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        shreg_d  = shreg_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && ready_i) begin
                    state_d = S_IDLE;
                end
                // Back-to-back: in DONE the consume and the next accept share an edge.
                if (accept) begin
                    if (is_shift(ctrl_i)) begin
`ifdef ALU_FAST_SHIFT_EN
                        result_d = fast_res;
                        state_d  = S_DONE;
`else
                        if (amt_in == 5'd0) begin
                            result_d = src2_i;
                            state_d  = S_DONE;
                        end else begin
                            shreg_d = src2_i;
                            rem_d   = amt_in;
                            state_d = S_SHIFT;
                        end
`endif
                    end else begin
                        result_d = core_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = step_res;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    result_d = step_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            shreg_q  <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            shreg_q  <= shreg_d;
            rem_q    <= rem_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;
    int shift_rdy_bad = 0;

    alu_seq_exec #(.DATA_W(32), .SHIFT_STEP(1)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .shamt_i  (shamt_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .zero_o   (zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Called #1 after a posedge with the DUT idle. Latency counts the accept
    // cycle as 1, so a single-cycle op has latency 1.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit consume,
                         output logic [31:0] res, output logic z, output int lat);
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
        valid_i = 1'b1;
        ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready ctrl=%0d got=%b want=1", c, ready_o);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ctrl_i  = 4'($urandom);
        src1_i  = $urandom;
        src2_i  = $urandom;
        shamt_i = 5'($urandom);
        lat = 1;
        while (valid_o !== 1'b1 && lat < 200) begin
            if (ready_o !== 1'b0) shift_rdy_bad++;
            @(posedge clk_i); #1;
            lat++;
        end
        res = result_o;
        z   = zero_o;
        if (consume) begin
            ready_i = 1'b1;
            @(posedge clk_i); #1;
            ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        checks++;
        if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result_o); end
        checks++;
        if (zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b want=1", zero_o); end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  c [10] = '{4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd10, 4'd15, 4'd7, 4'd4};
        logic [31:0] a [10] = '{32'hFFFF_FFFF, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                                32'hF0F0_1234, 32'd3, 32'd0, 32'h1234_5678, 32'd9, 32'd100};
        logic [31:0] b [10] = '{32'd1, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF,
                                32'h0FF0_00FF, 32'd5, 32'h0000_ABCD, 32'h1, 32'd8, 32'd23};
        logic [31:0] e [10] = '{32'h0, 32'h00F0_0034, 32'hFFF0_12FF, 32'hFF0F_FFCB,
                                32'h000F_ED00, 32'hFFFF_FFFE, 32'hABCD_0000, 32'h0, 32'h0, 32'd123};
        logic [31:0] r;
        logic        z;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            do_op(c[i], a[i], b[i], 5'd0, 1'b1, r, z, lat);
            checks++;
            if (r !== e[i]) begin errors++; $display("FAIL single_result ctrl=%0d got=%h want=%h", c[i], r, e[i]); end
            checks++;
            if (z !== (e[i] == 32'h0)) begin errors++; $display("FAIL single_zero ctrl=%0d got=%b want=%b", c[i], z, e[i] == 32'h0); end
            checks++;
            if (lat != 1) begin errors++; $display("FAIL single_latency ctrl=%0d got=%0d want=1", c[i], lat); end
        end
    endtask

    task automatic test_compare();
        logic [3:0]  c [4] = '{4'd6, 4'd11, 4'd7, 4'd13};
        logic [31:0] a [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hDEAD_BEEF};
        logic [31:0] b [4] = '{32'd1, 32'd1, 32'd5, 32'h1234_5678};
        logic [31:0] e [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
        logic [31:0] r;
        logic        z;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            do_op(c[i], a[i], b[i], 5'd3, 1'b1, r, z, lat);
            checks++;
            if (r !== e[i]) begin errors++; $display("FAIL compare_result ctrl=%0d got=%h want=%h", c[i], r, e[i]); end
            checks++;
            if (z !== (e[i] == 32'h0)) begin errors++; $display("FAIL compare_zero ctrl=%0d got=%b want=%b", c[i], z, e[i] == 32'h0); end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  c [4] = '{4'd8, 4'd8, 4'd9, 4'd8};
        logic [31:0] a [4] = '{32'h0, 32'h0, 32'd31, 32'hFFFF_FFE0};
        logic [31:0] b [4] = '{32'h8000_0000, 32'h7F00_1200, 32'h8000_0000, 32'h8123_4567};
        logic [4:0]  s [4] = '{5'd4, 5'd8, 5'd17, 5'd0};
        logic [31:0] e [4] = '{32'hF800_0000, 32'h007F_0012, 32'hFFFF_FFFF, 32'h8123_4567};
        int          k [4] = '{4, 8, 31, 0};
        logic [31:0] r;
        logic        z;
        int          lat;
        int          want_lat;
        for (int i = 0; i < 4; i++) begin
            shift_rdy_bad = 0;
            do_op(c[i], a[i], b[i], s[i], 1'b1, r, z, lat);
            want_lat = FAST ? 1 : k[i] + 1;
            checks++;
            if (r !== e[i]) begin errors++; $display("FAIL shift_result ctrl=%0d got=%h want=%h", c[i], r, e[i]); end
            checks++;
            if (lat != want_lat) begin errors++; $display("FAIL shift_latency ctrl=%0d got=%0d want=%0d", c[i], lat, want_lat); end
            checks++;
            if (shift_rdy_bad != 0) begin errors++; $display("FAIL shift_ready_low cycles_high=%0d want=0", shift_rdy_bad); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic        z;
        int          lat;
        do_op(4'd4, 32'd10, 32'd20, 5'd0, 1'b0, r, z, lat);
        // stall in DONE with a new SUBU pending
        ctrl_i  = 4'd5;
        src1_i  = 32'd10;
        src2_i  = 32'd3;
        valid_i = 1'b1;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (result_o !== 32'd30) begin errors++; $display("FAIL stall_result cyc=%0d got=%h want=%h", i, result_o, 32'd30); end
            checks++;
            if (valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got=%b want=1", i, valid_o); end
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, ready_o); end
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", ready_o); end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b want=1", valid_o); end
        checks++;
        if (result_o !== 32'd7) begin errors++; $display("FAIL b2b_result got=%h want=%h", result_o, 32'd7); end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b want=0", valid_o); end
    endtask

    task automatic test_reset_midshift();
        logic [31:0] r;
        logic        z;
        int          lat;
        ctrl_i  = 4'd9;
        src1_i  = 32'd31;
        src2_i  = 32'h7FFF_FFFF;
        shamt_i = 5'd0;
        valid_i = 1'b1;
        ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b want=0", valid_o); end
        checks++;
        if (result_o !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h want=0", result_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b want=1", ready_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        do_op(4'd4, 32'd2, 32'd3, 5'd0, 1'b1, r, z, lat);
        checks++;
        if (r !== 32'd5) begin errors++; $display("FAIL postreset_addu got=%h want=%h", r, 32'd5); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL postreset_latency got=%0d want=1", lat); end
    endtask

    initial begin
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        ctrl_i  = 4'd0;
        src1_i  = 32'h0;
        src2_i  = 32'h0;
        shamt_i = 5'd0;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        test_single_cycle();
        test_compare();
        test_shift();
        test_back_to_back();
        test_reset_midshift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
